// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S mode constants and counter sizing helper
package i2s_pkg;
  localparam int I2S_MODE_I2S = 0;
  localparam int I2S_MODE_LJ = 1;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into BCLK and flags the cycle BCLK falls
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_evt
);
  localparam int DW = cnt_w(CLK_DIV);
  logic [DW-1:0] div_cnt;
  logic wrap;
  assign wrap = div_cnt == DW'(CLK_DIV - 1);
  assign fall_evt = wrap && bclk;
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      bclk <= bclk ^ wrap;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S / left-justified serializer with a one-pair holding buffer
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 18,
  parameter int SLOT_WIDTH = 32,
  parameter int CLK_DIV = 4,
  parameter int MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  output logic                    BCLK,
  output logic                    LRCLK,
  output logic                    SD,
  output logic                    underrun
);
  localparam int BW = cnt_w(2 * SLOT_WIDTH);
  localparam int PW = cnt_w(SLOT_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] HALF = BW'(SLOT_WIDTH);
  if (CLK_DIV < 1) begin : g_bad_div
    $error("i2s_tx: CLK_DIV must be at least 1");
  end
  if (MODE != I2S_MODE_I2S && MODE != I2S_MODE_LJ) begin : g_bad_mode
    $error("i2s_tx: MODE must be 0 or 1");
  end
  if ((MODE == I2S_MODE_I2S && SAMPLE_WIDTH >= SLOT_WIDTH) ||
      (MODE == I2S_MODE_LJ && SAMPLE_WIDTH > SLOT_WIDTH)) begin : g_bad_width
    $error("i2s_tx: SAMPLE_WIDTH does not fit in SLOT_WIDTH");
  end
  logic fall_evt, load, hs, buf_full;
  logic [SAMPLE_WIDTH-1:0] buf_l, buf_r, sh_l, sh_r, ld_l, ld_r, smp, shifted;
  logic [BW-1:0] bit_cnt, nb;
  logic [PW-1:0] p;
  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk(clk),
    .rst(rst),
    .bclk(BCLK),
    .fall_evt(fall_evt)
  );
  assign s_ready = !buf_full;
  assign hs = s_valid && s_ready && !rst;
  assign load = fall_evt && bit_cnt == LAST;
  // SD is computed from the post-load sample so the first slot bit is ready on the load edge
  always_comb begin
    nb = load ? '0 : bit_cnt + 1'b1;
    p = PW'(nb >= HALF ? nb - HALF : nb);
    ld_l = load ? (buf_full ? buf_l : '0) : sh_l;
    ld_r = load ? (buf_full ? buf_r : '0) : sh_r;
    smp = nb >= HALF ? ld_r : ld_l;
    shifted = MODE == I2S_MODE_LJ ? smp << p : (p == '0 ? '0 : smp << (p - 1'b1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= LAST;
      LRCLK <= 1'b1;
      SD <= 1'b0;
      underrun <= 1'b0;
      buf_full <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
      sh_l <= '0;
      sh_r <= '0;
    end else begin
      underrun <= load && !buf_full;
      buf_full <= hs || (buf_full && !load);
      if (hs) begin
        buf_l <= s_left;
        buf_r <= s_right;
      end
      if (fall_evt) begin
        bit_cnt <= nb;
        LRCLK <= nb >= HALF;
        SD <= shifted[SAMPLE_WIDTH-1];
        sh_l <= ld_l;
        sh_r <= ld_r;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench running I2S and left-justified instances side by side
module tb_i2s_tx;
  logic clk, rst, s_valid;
  logic [17:0] s_left, s_right;
  logic s_ready0, bclk0, lrclk0, sd0, underrun0;
  logic s_ready1, bclk1, lrclk1, sd1, underrun1;
  int n_chk = 0, n_fail = 0, ur_cnt = 0, hs_cnt = 0, hs0;
  i2s_tx #(.SAMPLE_WIDTH(18), .SLOT_WIDTH(32), .CLK_DIV(2), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
    .s_left(s_left), .s_right(s_right), .BCLK(bclk0), .LRCLK(lrclk0),
    .SD(sd0), .underrun(underrun0)
  );
  i2s_tx #(.SAMPLE_WIDTH(18), .SLOT_WIDTH(32), .CLK_DIV(2), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
    .s_left(s_left), .s_right(s_right), .BCLK(bclk1), .LRCLK(lrclk1),
    .SD(sd1), .underrun(underrun1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (underrun0) ur_cnt++;
    if (s_valid && s_ready0 && !rst) hs_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic exp_sd(input int mode, input logic [17:0] smp, input int p);
    logic [17:0] t;
    if (mode == 1) begin
      if (p >= 18) return 1'b0;
      t = smp >> (17 - p);
    end else begin
      if (p < 1 || p > 18) return 1'b0;
      t = smp >> (18 - p);
    end
    return t[0];
  endfunction
  task automatic wait_fall();
    logic prev;
    int n;
    prev = bclk0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (prev && !bclk0) return;
      prev = bclk0;
    end
    check("fall timeout", 0, 1);
  endtask
  task automatic push(input logic [17:0] l, input logic [17:0] r);
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask
  task automatic check_frame(input logic [17:0] l, input logic [17:0] r, input logic ur0,
                             input logic rdy0, input logic cont, input logic hs_load);
    for (int k = 0; k < 64; k++) begin
      logic [17:0] smp;
      int p;
      if (k == 0 && hs_load) begin
        repeat (3) @(posedge clk);
        #1;
        s_left = l;
        s_right = r;
        s_valid = 1'b1;
      end
      wait_fall();
      if (k == 0 && hs_load) s_valid = 1'b0;
      smp = hs_load ? 18'h0 : (k < 32 ? l : r);
      p = k % 32;
      check($sformatf("lrclk0 k=%0d", k), lrclk0, k >= 32);
      check($sformatf("lrclk1 k=%0d", k), lrclk1, k >= 32);
      check($sformatf("sd0 k=%0d", k), sd0, exp_sd(0, smp, p));
      check($sformatf("sd1 k=%0d", k), sd1, exp_sd(1, smp, p));
      check($sformatf("underrun k=%0d", k), underrun0, k == 0 ? ur0 : 1'b0);
      if (k == 0) begin
        check("ready at load", s_ready0, rdy0);
        if (cont) begin
          @(posedge clk);
          #1;
          check("ready after hs", s_ready0, 0);
        end
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_left = '0;
    s_right = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst bclk", bclk0, 0);
    check("rst lrclk", lrclk0, 1);
    check("rst sd", sd0, 0);
    check("rst ready", s_ready0, 1);
    check("rst ready1", s_ready1, 1);
    check("rst underrun", underrun0, 0);
    rst = 1'b0;
    push(18'h20001, 18'h1FFFE);
    check("ready after push", s_ready0, 0);
    check_frame(18'h20001, 18'h1FFFE, 0, 1, 0, 0);
    repeat (3) check_frame(18'h0, 18'h0, 1, 1, 0, 0);
    check("underrun x3", ur_cnt, 3);
    hs0 = hs_cnt;
    s_left = 18'h2AAAA;
    s_right = 18'h15555;
    s_valid = 1'b1;
    repeat (3) check_frame(18'h2AAAA, 18'h15555, 0, 1, 1, 0);
    s_valid = 1'b0;
    check("hs per frame", hs_cnt - hs0, 4);
    check_frame(18'h2AAAA, 18'h15555, 0, 1, 0, 0);
    push(18'h3FFFF, 18'h3FFFF);
    for (int k = 0; k <= 40; k++) begin
      wait_fall();
      if (k == 0) begin
        check("no underrun f5", underrun0, 0);
        push(18'h11111, 18'h11111);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check("pre-rst bclk", bclk0, 1);
    check("pre-rst lrclk", lrclk0, 1);
    check("pre-rst sd", sd0, 1);
    check("pre-rst ready", s_ready0, 0);
    rst = 1'b1;
    s_valid = 1'b1;
    s_left = 18'h0F0F0;
    s_right = 18'h0F0F0;
    @(posedge clk);
    #1;
    check("mid-rst bclk", bclk0, 0);
    check("mid-rst lrclk", lrclk0, 1);
    check("mid-rst sd", sd0, 0);
    check("mid-rst ready", s_ready0, 1);
    check("mid-rst underrun", underrun0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(18'h12345, 18'h3C0F0);
    check("ready after rst push", s_ready0, 0);
    check_frame(18'h12345, 18'h3C0F0, 0, 1, 0, 0);
    check_frame(18'h00001, 18'h20000, 1, 0, 0, 1);
    check_frame(18'h00001, 18'h20000, 0, 1, 0, 0);
    check("underrun total", ur_cnt, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
